// File: rtl/mesa_nib_framer_pkg.sv
// Shared state encoding and framing constants for the mesa nibble framer.
package mesa_nib_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_t;

  localparam logic [7:0] PREAMBLE_DEF = 8'hF0;
  localparam int         HDR_BYTES    = 3;

endpackage

// File: rtl/mesa_nib_framer_pair.sv
// Pairs incoming nibbles (high first) into bytes; byte_en pulses one clock
// after the low nibble strobe.
module mesa_nib_framer_pair (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nib_en,
  input  logic [3:0] nib_d,
  input  logic       phase_clr,
  output logic       phase,
  output logic       byte_en,
  output logic [7:0] byte_d
);

  logic [3:0] hi_nib;

  // A timeout only clears the phase when no nibble arrives in the same clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase   <= 1'b0;
      hi_nib  <= 4'h0;
      byte_en <= 1'b0;
      byte_d  <= 8'h00;
    end else begin
      byte_en <= 1'b0;
      if (nib_en) begin
        if (!phase) begin
          hi_nib <= nib_d;
        end else begin
          byte_d  <= {hi_nib, nib_d};
          byte_en <= 1'b1;
        end
        phase <= ~phase;
      end else if (phase_clr) begin
        phase <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mesa_nib_framer.sv
// Receive framer: hunts for the preamble, captures the 3-byte header and
// forwards payload bytes, with an inactivity timeout for resync.
module mesa_nib_framer
  import mesa_nib_framer_pkg::*;
#(
  parameter int         TO_BITS  = 24,
  parameter int         TIMEOUT  = 1000000,
  parameter logic [7:0] PREAMBLE = PREAMBLE_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_nib_en,
  input  logic [3:0] rx_nib_d,
  output logic       hdr_vld,
  output logic [7:0] hdr_slot,
  output logic [3:0] hdr_subslot,
  output logic [3:0] hdr_cmd,
  output logic [7:0] hdr_len,
  output logic       pay_en,
  output logic [7:0] pay_d,
  output logic       pkt_done,
  output logic       timeout_err
);

  localparam logic [TO_BITS-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_BITS'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [1:0]         idx, idx_nxt;
  logic [7:0]         remain, remain_nxt;
  logic [7:0]         slot_sh, byte1_sh;
  logic               done_pend;
  logic [TO_BITS-1:0] to_cnt;
  logic               phase, byte_en, active, expire;
  logic [7:0]         byte_d;
  logic               hdr_cap, hdr_fire, pay_fire, done_now, done_later;

  mesa_nib_framer_pair u_pair (
    .clk       (clk),
    .reset_n   (reset_n),
    .nib_en    (rx_nib_en),
    .nib_d     (rx_nib_d),
    .phase_clr (expire),
    .phase     (phase),
    .byte_en   (byte_en),
    .byte_d    (byte_d)
  );

  // A nibble arriving on the expiry clock keeps the frame alive.
  assign active = (state != ST_IDLE) || phase;
  assign expire = (TIMEOUT != 0) && !rx_nib_en && active && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    remain_nxt = remain;
    hdr_cap    = 1'b0;
    hdr_fire   = 1'b0;
    pay_fire   = 1'b0;
    done_now   = 1'b0;
    done_later = 1'b0;
    if (expire) begin
      state_nxt = ST_IDLE;
      idx_nxt   = 2'd0;
    end else if (byte_en) begin
      case (state)
        ST_IDLE: begin
          if (byte_d == PREAMBLE) begin
            state_nxt = ST_HDR;
            idx_nxt   = 2'd0;
          end
        end
        ST_HDR: begin
          hdr_cap = 1'b1;
          idx_nxt = idx + 2'd1;
          if (idx == 2'(HDR_BYTES - 1)) begin
            hdr_fire = 1'b1;
            idx_nxt  = 2'd0;
            if (byte_d == 8'd0) begin
              done_now  = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              remain_nxt = byte_d;
              state_nxt  = ST_PAY;
            end
          end
        end
        ST_PAY: begin
          pay_fire   = 1'b1;
          remain_nxt = remain - 8'd1;
          if (remain == 8'd1) begin
            done_later = 1'b1;
            state_nxt  = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      idx         <= 2'd0;
      remain      <= 8'd0;
      slot_sh     <= 8'd0;
      byte1_sh    <= 8'd0;
      done_pend   <= 1'b0;
      to_cnt      <= '0;
      hdr_vld     <= 1'b0;
      hdr_slot    <= 8'd0;
      hdr_subslot <= 4'd0;
      hdr_cmd     <= 4'd0;
      hdr_len     <= 8'd0;
      pay_en      <= 1'b0;
      pay_d       <= 8'd0;
      pkt_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      remain      <= remain_nxt;
      done_pend   <= done_later;
      hdr_vld     <= hdr_fire;
      pay_en      <= pay_fire;
      pkt_done    <= done_now | done_pend;
      timeout_err <= expire;
      if (hdr_cap && idx == 2'd0) slot_sh  <= byte_d;
      if (hdr_cap && idx == 2'd1) byte1_sh <= byte_d;
      if (hdr_fire) begin
        hdr_slot    <= slot_sh;
        hdr_subslot <= byte1_sh[7:4];
        hdr_cmd     <= byte1_sh[3:0];
        hdr_len     <= byte_d;
      end
      if (pay_fire) pay_d <= byte_d;
      if (rx_nib_en || expire) begin
        to_cnt <= '0;
      end else if (active && to_cnt != {TO_BITS{1'b1}}) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mesa_nib_framer.sv
// Bench for mesa_nib_framer: frame table, hand-written corner sequences and
// randomized traffic checked every clock against a byte-level reference model.
module tb_mesa_nib_framer;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_nib_en = 1'b0;
  logic [3:0] rx_nib_d = 4'h0;
  logic       hdr_vld, pay_en, pkt_done, timeout_err;
  logic [7:0] hdr_slot, hdr_len, pay_d;
  logic [3:0] hdr_subslot, hdr_cmd;

  always #5 clk = ~clk;

  mesa_nib_framer #(.TO_BITS(8), .TIMEOUT(TIMEOUT), .PREAMBLE(8'hF0)) dut (
    .clk(clk), .reset_n(reset_n), .rx_nib_en(rx_nib_en), .rx_nib_d(rx_nib_d),
    .hdr_vld(hdr_vld), .hdr_slot(hdr_slot), .hdr_subslot(hdr_subslot), .hdr_cmd(hdr_cmd),
    .hdr_len(hdr_len), .pay_en(pay_en), .pay_d(pay_d), .pkt_done(pkt_done),
    .timeout_err(timeout_err)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  // Reference model: tracks frame progress in terms of bytes, not RTL states.
  int         m_got, m_left, m_idle;
  logic [7:0] m_hdr [3];
  bit         m_phase, m_pend, m_done_next;
  logic [3:0] m_hi;
  logic [7:0] m_byte;
  logic       x_vld, x_pay, x_done, x_to;
  logic [7:0] x_slot, x_len, x_payd;
  logic [3:0] x_sub, x_cmd;

  int         obs_hdr, obs_done, obs_to;
  logic [7:0] obs_slot, obs_len;
  logic [3:0] obs_sub, obs_cmd;
  logic [7:0] obs_pay [$];
  int         last_nib_cyc, last_pay_cyc, hdr_cyc, done_cyc, to_cyc;

  typedef struct {
    logic [63:0] nibs;
    int          n;
    logic [7:0]  e_slot;
    logic [3:0]  e_sub;
    logic [3:0]  e_cmd;
    logic [7:0]  e_len;
    logic [15:0] e_pay;
    int          e_npay;
  } vec_t;

  vec_t tbl [4];

  task automatic model_reset();
    m_got = -1; m_left = 0; m_idle = 0;
    m_phase = 0; m_pend = 0; m_done_next = 0; m_hi = 4'h0; m_byte = 8'h00;
    x_vld = 0; x_pay = 0; x_done = 0; x_to = 0;
    x_slot = 8'h00; x_len = 8'h00; x_payd = 8'h00; x_sub = 4'h0; x_cmd = 4'h0;
  endtask

  task automatic model_step(input logic en, input logic [3:0] d);
    bit active;
    x_vld = 0; x_pay = 0; x_to = 0;
    x_done = m_done_next;
    m_done_next = 0;
    active = (m_got >= 0) || (m_left > 0) || m_phase;
    if (TIMEOUT != 0 && !en && active && m_idle + 1 >= TIMEOUT) begin
      x_to = 1; m_got = -1; m_left = 0; m_phase = 0; m_idle = 0; m_pend = 0;
    end else begin
      if (en) m_idle = 0;
      else if (active) m_idle++;
      if (m_pend) begin
        if (m_left > 0) begin
          x_pay = 1; x_payd = m_byte; m_left--;
          if (m_left == 0) m_done_next = 1;
        end else if (m_got < 0) begin
          if (m_byte == 8'hF0) m_got = 0;
        end else begin
          m_hdr[m_got] = m_byte;
          m_got++;
          if (m_got == 3) begin
            x_vld = 1; x_slot = m_hdr[0]; x_sub = m_hdr[1][7:4]; x_cmd = m_hdr[1][3:0];
            x_len = m_hdr[2]; m_got = -1;
            if (m_hdr[2] == 8'h00) x_done = 1;
            else m_left = int'(m_hdr[2]);
          end
        end
        m_pend = 0;
      end
      if (en) begin
        if (!m_phase) begin
          m_hi = d; m_phase = 1;
        end else begin
          m_byte = {m_hi, d}; m_pend = 1; m_phase = 0;
        end
      end
    end
  endtask

  function automatic logic [35:0] dut_vec();
    return {hdr_vld, hdr_slot, hdr_subslot, hdr_cmd, hdr_len, pay_en, pay_d, pkt_done, timeout_err};
  endfunction

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_output();
    check_val("cycle_outputs", {28'd0, dut_vec()},
              {28'd0, x_vld, x_slot, x_sub, x_cmd, x_len, x_pay, x_payd, x_done, x_to});
  endtask

  task automatic apply_stimulus(input logic en, input logic [3:0] d);
    rx_nib_en = en;
    rx_nib_d  = d;
    @(posedge clk);
    cyc++;
    model_step(en, d);
    #1;
    check_output();
    if (en) last_nib_cyc = cyc;
    if (hdr_vld) begin
      obs_hdr++; obs_slot = hdr_slot; obs_sub = hdr_subslot; obs_cmd = hdr_cmd;
      obs_len = hdr_len; hdr_cyc = cyc;
    end
    if (pay_en) begin obs_pay.push_back(pay_d); last_pay_cyc = cyc; end
    if (pkt_done) begin obs_done++; done_cyc = cyc; end
    if (timeout_err) begin obs_to++; to_cyc = cyc; end
  endtask

  task automatic clear_obs();
    obs_hdr = 0; obs_done = 0; obs_to = 0; obs_pay.delete();
    obs_slot = 8'h00; obs_len = 8'h00; obs_sub = 4'h0; obs_cmd = 4'h0;
    last_pay_cyc = -1; hdr_cyc = -1; done_cyc = -1; to_cyc = -1;
  endtask

  task automatic settle();
    repeat (TIMEOUT + 4) apply_stimulus(1'b0, 4'h0);
    clear_obs();
  endtask

  task automatic send_nibs(input logic [63:0] nibs, input int n, input int gap);
    logic [3:0] nb;
    for (int k = 0; k < n; k++) begin
      nb = nibs[63-4*k -: 4];
      apply_stimulus(1'b1, nb);
      repeat (gap) apply_stimulus(1'b0, 4'h0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmax);
    apply_stimulus(1'b1, b[7:4]);
    repeat ($urandom_range(0, gmax)) apply_stimulus(1'b0, 4'h0);
    apply_stimulus(1'b1, b[3:0]);
    repeat ($urandom_range(0, gmax)) apply_stimulus(1'b0, 4'h0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] slot, input logic [7:0] len,
                             input logic [7:0] pay0);
    check_val({tag, "_hdr_count"}, obs_hdr, 1);
    check_val({tag, "_slot"}, obs_slot, slot);
    check_val({tag, "_len"}, obs_len, len);
    check_val({tag, "_pay_count"}, obs_pay.size(), len);
    if (obs_pay.size() > 0) check_val({tag, "_pay0"}, obs_pay[0], pay0);
    check_val({tag, "_done_count"}, obs_done, 1);
  endtask

  initial begin
    tbl[0] = '{64'hF0221302ABCD0000, 12, 8'h22, 4'h1, 4'h3, 8'h02, 16'hABCD, 2};
    tbl[1] = '{64'hF000000000000000,  8, 8'h00, 4'h0, 4'h0, 8'h00, 16'h0000, 0};
    tbl[2] = '{64'h1234F0A57C01F000, 14, 8'hA5, 4'h7, 4'hC, 8'h01, 16'hF000, 1};
    tbl[3] = '{64'hF03C5A02F0F00000, 12, 8'h3C, 4'h5, 4'hA, 8'h02, 16'hF0F0, 2};

    model_reset();
    clear_obs();
    last_nib_cyc = -1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", {28'd0, dut_vec()}, 64'd0);
    reset_n = 1'b1;

    // Table of complete frames, alternating back-to-back and gapped nibbles.
    for (int i = 0; i < 4; i++) begin
      settle();
      send_nibs(tbl[i].nibs, tbl[i].n, i % 2);
      repeat (4) apply_stimulus(1'b0, 4'h0);
      check_val("tbl_hdr_count", obs_hdr, 1);
      check_val("tbl_slot", obs_slot, tbl[i].e_slot);
      check_val("tbl_subslot", obs_sub, tbl[i].e_sub);
      check_val("tbl_cmd", obs_cmd, tbl[i].e_cmd);
      check_val("tbl_len", obs_len, tbl[i].e_len);
      check_val("tbl_pay_count", obs_pay.size(), tbl[i].e_npay);
      for (int j = 0; j < tbl[i].e_npay; j++)
        if (j < obs_pay.size()) check_val("tbl_pay_byte", obs_pay[j], tbl[i].e_pay[15-8*j -: 8]);
      check_val("tbl_done_count", obs_done, 1);
      check_val("tbl_timeout_count", obs_to, 0);
      if (tbl[i].e_npay == 0) begin
        check_val("len0_hdr_latency", hdr_cyc, last_nib_cyc + 1);
        check_val("len0_done_with_hdr", done_cyc, hdr_cyc);
      end else begin
        check_val("pay_latency", last_pay_cyc, last_nib_cyc + 1);
        check_val("done_after_pay", done_cyc, last_pay_cyc + 1);
      end
    end

    // Odd garbage leaves nibble phase misaligned until the timeout resyncs it.
    settle();
    send_nibs(64'h123F022000000000, 7, 0);
    repeat (TIMEOUT + 4) apply_stimulus(1'b0, 4'h0);
    check_val("garbage_timeout_count", obs_to, 1);
    check_val("garbage_timeout_cycle", to_cyc, last_nib_cyc + TIMEOUT);
    check_val("garbage_no_hdr", obs_hdr, 0);
    clear_obs();
    send_nibs(tbl[0].nibs, tbl[0].n, 1);
    repeat (4) apply_stimulus(1'b0, 4'h0);
    check_frame("post_timeout", 8'h22, 8'h02, 8'hAB);

    // Nibble on the last idle clock before expiry keeps the frame alive.
    settle();
    send_nibs(64'hF022000000000000, 4, 0);
    repeat (TIMEOUT - 1) apply_stimulus(1'b0, 4'h0);
    send_nibs(64'h13017E0000000000, 6, 0);
    repeat (4) apply_stimulus(1'b0, 4'h0);
    check_val("edge_no_timeout", obs_to, 0);
    check_frame("edge_frame", 8'h22, 8'h01, 8'h7E);

    // One clock later the frame is aborted instead.
    settle();
    send_nibs(64'hF022000000000000, 4, 0);
    repeat (TIMEOUT) apply_stimulus(1'b0, 4'h0);
    check_val("late_timeout_cycle", to_cyc, last_nib_cyc + TIMEOUT);
    send_nibs(64'h13017E0000000000, 6, 0);
    repeat (4) apply_stimulus(1'b0, 4'h0);
    check_val("late_timeout_count", obs_to, 1);
    check_val("late_no_hdr", obs_hdr, 0);

    // Asynchronous reset in the middle of a payload.
    settle();
    send_nibs(64'hF0221305AB000000, 10, 0);
    apply_stimulus(1'b0, 4'h0);
    check_val("pre_reset_pay_en", pay_en, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_reset_outputs", {28'd0, dut_vec()}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_obs();
    send_nibs(tbl[0].nibs, tbl[0].n, 0);
    repeat (TIMEOUT + 4) apply_stimulus(1'b0, 4'h0);
    check_frame("post_reset", 8'h22, 8'h02, 8'hAB);
    check_val("post_reset_no_timeout", obs_to, 0);

    // Randomized traffic with stray nibbles, gaps and aborted frames.
    for (int f = 0; f < 80; f++) begin
      int len;
      len = $urandom_range(0, 5);
      if ($urandom_range(0, 5) == 0) apply_stimulus(1'b1, 4'($urandom_range(0, 15)));
      send_byte(8'hF0, 2);
      send_byte(8'($urandom_range(0, 255)), 3);
      send_byte(8'($urandom_range(0, 255)), 3);
      send_byte(8'(len), 2);
      for (int p = 0; p < len; p++) begin
        if ($urandom_range(0, 15) == 0) repeat (TIMEOUT + 2) apply_stimulus(1'b0, 4'h0);
        send_byte(($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom_range(0, 255)), 2);
      end
      repeat (($urandom_range(0, 2) == 0) ? TIMEOUT + 2 : $urandom_range(0, 3))
        apply_stimulus(1'b0, 4'h0);
    end
    repeat (TIMEOUT + 4) apply_stimulus(1'b0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
